// File: rtl/vend_pkg.sv
// rtl/vend_pkg.sv - shared types, constants and helpers for the vending select core
//
// Purpose: state encoding, item/credit widths, default price table and small
//          arithmetic helpers used by vend_select_ctrl and its debouncers.
// Ports:   none (package).
package vend_pkg;

  localparam int NUM_ITEMS = 4;
  localparam int CREDIT_W  = 8;
  localparam int SEL_W     = $clog2(NUM_ITEMS);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SELECT   = 2'd1,
    DISPENSE = 2'd2
  } state_t;

  typedef logic [CREDIT_W-1:0] credit_t;
  typedef logic [NUM_ITEMS-1:0][CREDIT_W-1:0] price_arr_t;

  // Default prices: fries, burger, egg, coffee.
  localparam credit_t PRICE0_DEF = 8'd100;
  localparam credit_t PRICE1_DEF = 8'd150;
  localparam credit_t PRICE2_DEF = 8'd50;
  localparam credit_t PRICE3_DEF = 8'd75;

  function automatic price_arr_t build_prices(input credit_t p0, input credit_t p1,
                                              input credit_t p2, input credit_t p3);
    price_arr_t arr;
    arr[0] = p0;
    arr[1] = p1;
    arr[2] = p2;
    arr[3] = p3;
    return arr;
  endfunction

  localparam price_arr_t PRICES_DEF = build_prices(PRICE0_DEF, PRICE1_DEF, PRICE2_DEF, PRICE3_DEF);

  // Credit never wraps: clamp to all-ones on overflow.
  function automatic credit_t sat_add(input credit_t a, input credit_t b);
    logic [CREDIT_W:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    return sum[CREDIT_W] ? {CREDIT_W{1'b1}} : sum[CREDIT_W-1:0];
  endfunction

  // Index of the lowest set bit; scanning high-to-low lets the lowest overwrite.
  function automatic logic [SEL_W-1:0] lowest_index(input logic [NUM_ITEMS-1:0] v);
    logic [SEL_W-1:0] idx;
    idx = '0;
    for (int i = NUM_ITEMS - 1; i >= 0; i--) begin
      if (v[i]) idx = SEL_W'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/switch_debouncer.sv
// rtl/switch_debouncer.sv - synchronizer, stable-count debouncer and rise detector for one switch
//
// Purpose: brings one raw switch into the clock domain, accepts a new level only
//          after it has been stable for DEB_CYCLES cycles, and flags accepted rises.
// Ports:
//   i_clk    in  clock
//   i_rst_n  in  asynchronous active-low reset
//   i_sw     in  raw asynchronous switch level
//   o_rise   out one-cycle pulse when the debounced level goes 0 -> 1
module switch_debouncer #(
  parameter int DEB_CYCLES = 250000
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_sw,
  output logic o_rise
);

  localparam int CNT_W = (DEB_CYCLES < 2) ? 1 : $clog2(DEB_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);

  logic             r_sync1;
  logic             r_sync2;
  logic             r_deb;
  logic             r_rise;
  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_deb   <= 1'b0;
      r_rise  <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_sync1 <= i_sw;
      r_sync2 <= r_sync1;
      r_rise  <= 1'b0;
      if (r_sync2 != r_deb) begin
        // The count covers consecutive differing cycles; this is the last one.
        if (r_cnt == CNT_LAST) begin
          r_deb  <= r_sync2;
          r_rise <= r_sync2;
          r_cnt  <= '0;
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
      end else begin
        // Any return to the accepted level restarts the stability window.
        r_cnt <= '0;
      end
    end
  end

  assign o_rise = r_rise;

endmodule

// File: rtl/vend_select_ctrl.sv
// rtl/vend_select_ctrl.sv - vending control core: select arbitration, credit, dispense, frame-synced status
//
// Purpose: debounces item switches, picks one item, accumulates coin credit,
//          sequences a timed dispense and publishes a frame-synchronous highlight.
// Ports:
//   clk_25         in  pixel clock, sole clock
//   rst_n          in  asynchronous active-low reset
//   sw[3:0]        in  raw item switches
//   coin           in  coin-accepted level, one rise per coin
//   cancel         in  cancel button level
//   vsync_out      in  vertical sync, active low
//   disp_status    out one-hot highlighted item, updated once per frame
//   credit[7:0]    out current credit, saturating
//   dispense[3:0]  out one-cycle release pulse per item
//   change_valid   out one-cycle pulse qualifying change_amount
//   change_amount  out credit returned on cancel
//   busy           out high while dispensing
module vend_select_ctrl
  import vend_pkg::*;
#(
  parameter int      DEB_CYCLES      = 250000,
  parameter int      DISPENSE_CYCLES = 25000000,
  parameter int      COIN_VALUE      = 25,
  parameter credit_t PRICE0          = PRICE0_DEF,
  parameter credit_t PRICE1          = PRICE1_DEF,
  parameter credit_t PRICE2          = PRICE2_DEF,
  parameter credit_t PRICE3          = PRICE3_DEF
) (
  input  logic                 clk_25,
  input  logic                 rst_n,
  input  logic [NUM_ITEMS-1:0] sw,
  input  logic                 coin,
  input  logic                 cancel,
  input  logic                 vsync_out,
  output logic [NUM_ITEMS-1:0] disp_status,
  output logic [CREDIT_W-1:0]  credit,
  output logic [NUM_ITEMS-1:0] dispense,
  output logic                 change_valid,
  output logic [CREDIT_W-1:0]  change_amount,
  output logic                 busy
);

  localparam price_arr_t C_PRICES   = build_prices(PRICE0, PRICE1, PRICE2, PRICE3);
  localparam credit_t    C_COIN     = CREDIT_W'(COIN_VALUE);
  localparam int         DCNT_W     = (DISPENSE_CYCLES < 2) ? 1 : $clog2(DISPENSE_CYCLES + 1);
  localparam logic [DCNT_W-1:0] DCNT_LAST = DCNT_W'(DISPENSE_CYCLES - 1);

  // Switch debounce and select events
  logic [NUM_ITEMS-1:0] w_sw_rise;

  for (genvar gi = 0; gi < NUM_ITEMS; gi++) begin : g_deb
    switch_debouncer #(
      .DEB_CYCLES(DEB_CYCLES)
    ) u_deb (
      .i_clk  (clk_25),
      .i_rst_n(rst_n),
      .i_sw   (sw[gi]),
      .o_rise (w_sw_rise[gi])
    );
  end

  // Synchronizers plus one history flop each for edge detection
  logic r_coin_s1, r_coin_s2, r_coin_d;
  logic r_cancel_s1, r_cancel_s2, r_cancel_d;
  logic r_vs_s1, r_vs_s2, r_vs_d;
  logic r_vs_fall_d;

  always_ff @(posedge clk_25 or negedge rst_n) begin
    if (!rst_n) begin
      r_coin_s1   <= 1'b0;
      r_coin_s2   <= 1'b0;
      r_coin_d    <= 1'b0;
      r_cancel_s1 <= 1'b0;
      r_cancel_s2 <= 1'b0;
      r_cancel_d  <= 1'b0;
      r_vs_s1     <= 1'b0;
      r_vs_s2     <= 1'b0;
      r_vs_d      <= 1'b0;
    end else begin
      r_coin_s1   <= coin;
      r_coin_s2   <= r_coin_s1;
      r_coin_d    <= r_coin_s2;
      r_cancel_s1 <= cancel;
      r_cancel_s2 <= r_cancel_s1;
      r_cancel_d  <= r_cancel_s2;
      r_vs_s1     <= vsync_out;
      r_vs_s2     <= r_vs_s1;
      r_vs_d      <= r_vs_s2;
    end
  end

  logic w_coin_rise;
  logic w_cancel_rise;
  logic w_vs_fall;

  assign w_coin_rise   = r_coin_s2 & ~r_coin_d;
  assign w_cancel_rise = r_cancel_s2 & ~r_cancel_d;
  assign w_vs_fall     = r_vs_d & ~r_vs_s2;

  // FSM and datapath state
  state_t             r_state;
  logic [SEL_W-1:0]   r_sel;
  credit_t            r_credit;
  logic [NUM_ITEMS-1:0] r_dispense;
  logic               r_change_valid;
  credit_t            r_change_amount;
  logic               r_busy;
  logic [DCNT_W-1:0]  r_dcnt;
  logic [NUM_ITEMS-1:0] r_disp_status;

  logic             w_sel_evt;
  logic [SEL_W-1:0] w_sel_idx;
  logic [SEL_W-1:0] w_new_sel;
  credit_t          w_next_credit;
  credit_t          w_price;
  logic             w_can_buy;

  assign w_sel_evt     = |w_sw_rise;
  assign w_sel_idx     = lowest_index(w_sw_rise);
  assign w_new_sel     = w_sel_evt ? w_sel_idx : r_sel;
  // Credit including a coin landing this cycle; every purchase and refund uses it.
  assign w_next_credit = w_coin_rise ? sat_add(r_credit, C_COIN) : r_credit;
  assign w_price       = C_PRICES[w_new_sel];
  assign w_can_buy     = (w_next_credit >= w_price);

  always_ff @(posedge clk_25 or negedge rst_n) begin
    if (!rst_n) begin
      r_state         <= IDLE;
      r_sel           <= '0;
      r_credit        <= '0;
      r_dispense      <= '0;
      r_change_valid  <= 1'b0;
      r_change_amount <= '0;
      r_busy          <= 1'b0;
      r_dcnt          <= '0;
    end else begin
      r_dispense     <= '0;
      r_change_valid <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_cancel_rise) begin
            r_change_amount <= w_next_credit;
            r_change_valid  <= 1'b1;
            r_credit        <= '0;
            r_sel           <= '0;
          end else begin
            r_credit <= w_next_credit;
            if (w_sel_evt) begin
              r_sel   <= w_sel_idx;
              r_state <= SELECT;
            end
          end
        end
        SELECT: begin
          // Cancel outranks both a reselect and a purchase in the same cycle.
          if (w_cancel_rise) begin
            r_change_amount <= w_next_credit;
            r_change_valid  <= 1'b1;
            r_credit        <= '0;
            r_sel           <= '0;
            r_state         <= IDLE;
          end else if (w_can_buy) begin
            r_credit             <= w_next_credit - w_price;
            r_sel                <= w_new_sel;
            r_dispense[w_new_sel] <= 1'b1;
            r_busy               <= 1'b1;
            r_dcnt               <= '0;
            r_state              <= DISPENSE;
          end else begin
            r_credit <= w_next_credit;
            r_sel    <= w_new_sel;
          end
        end
        DISPENSE: begin
          // Only coins are honoured while the item is being released.
          r_credit <= w_next_credit;
          if (r_dcnt == DCNT_LAST) begin
            r_busy  <= 1'b0;
            r_dcnt  <= '0;
            r_state <= IDLE;
          end else begin
            r_dcnt <= r_dcnt + 1'b1;
          end
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  // Highlight only changes at the start of vertical blanking so a frame never tears.
  always_ff @(posedge clk_25 or negedge rst_n) begin
    if (!rst_n) begin
      r_vs_fall_d   <= 1'b0;
      r_disp_status <= '0;
    end else begin
      r_vs_fall_d <= w_vs_fall;
      if (r_vs_fall_d) begin
        r_disp_status <= (r_state == IDLE) ? '0 : (NUM_ITEMS'(1) << r_sel);
      end
    end
  end

  assign disp_status   = r_disp_status;
  assign credit        = r_credit;
  assign dispense      = r_dispense;
  assign change_valid  = r_change_valid;
  assign change_amount = r_change_amount;
  assign busy          = r_busy;

endmodule

// File: tb/tb_vend_select_ctrl.sv
// tb/tb_vend_select_ctrl.sv - self-checking bench for vend_select_ctrl
module tb_vend_select_ctrl;

  localparam int DEB = 4;
  localparam int DSP = 8;
  localparam int CV  = 25;

  logic       clk_25 = 1'b0;
  logic       rst_n  = 1'b0;
  logic [3:0] sw     = 4'b0;
  logic       coin   = 1'b0;
  logic       cancel = 1'b0;
  logic       vsync_out = 1'b1;
  logic [3:0] disp_status;
  logic [7:0] credit;
  logic [3:0] dispense;
  logic       change_valid;
  logic [7:0] change_amount;
  logic       busy;

  vend_select_ctrl #(
    .DEB_CYCLES(DEB),
    .DISPENSE_CYCLES(DSP),
    .COIN_VALUE(CV)
  ) dut (
    .clk_25(clk_25),
    .rst_n(rst_n),
    .sw(sw),
    .coin(coin),
    .cancel(cancel),
    .vsync_out(vsync_out),
    .disp_status(disp_status),
    .credit(credit),
    .dispense(dispense),
    .change_valid(change_valid),
    .change_amount(change_amount),
    .busy(busy)
  );

  always #5 clk_25 = ~clk_25;

  int n_checks = 0;
  int n_fail   = 0;
  int price [4] = '{100, 150, 50, 75};

  // Monitor: only this process writes the logs.
  logic [3:0] disp_log[$];
  logic [7:0] chg_log[$];
  int         busy_cycles = 0;

  always @(negedge clk_25) begin
    if (rst_n) begin
      if (dispense != 4'b0) disp_log.push_back(dispense);
      if (change_valid) chg_log.push_back(change_amount);
      if (busy) busy_cycles++;
    end
  end

  // Transaction-level reference model
  int         m_credit = 0;
  bit         m_active = 0;
  int         m_sel    = 0;
  logic [3:0] exp_disp[$];
  int         exp_chg[$];

  function automatic bit m_try_buy();
    if (m_active && m_credit >= price[m_sel]) begin
      m_credit = m_credit - price[m_sel];
      exp_disp.push_back(4'(1 << m_sel));
      m_active = 0;
      return 1'b1;
    end
    return 1'b0;
  endfunction

  function automatic logic [3:0] m_disp();
    return m_active ? 4'(1 << m_sel) : 4'b0;
  endfunction

  task automatic step(input int n);
    repeat (n) @(posedge clk_25);
    #2;
  endtask

  task automatic do_coin();
    bit b;
    coin = 1'b1; step(3); coin = 1'b0; step(3);
    m_credit = (m_credit + CV > 255) ? 255 : m_credit + CV;
    b = m_try_buy();
    if (b) step(12);
  endtask

  task automatic do_press(input int i);
    bit b;
    sw[i] = 1'b1; step(12); sw[i] = 1'b0; step(12);
    m_sel = i; m_active = 1;
    b = m_try_buy();
    if (b) step(4);
  endtask

  task automatic do_cancel();
    cancel = 1'b1; step(3); cancel = 1'b0; step(3);
    exp_chg.push_back(m_credit);
    m_credit = 0; m_active = 0;
  endtask

  task automatic do_frame();
    vsync_out = 1'b0; step(3); vsync_out = 1'b1; step(5);
  endtask

  task automatic test_reset();
    step(3);
    n_checks++; if (disp_status !== 4'b0) begin n_fail++; $display("FAIL reset_disp_status: got %b want 0000", disp_status); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
    rst_n = 1'b1;
    step(3);
    n_checks++; if (credit !== 8'd0) begin n_fail++; $display("FAIL reset_credit: got %0d want 0", credit); end
    n_checks++; if (dispense !== 4'b0) begin n_fail++; $display("FAIL reset_dispense: got %b want 0000", dispense); end
    n_checks++; if (change_valid !== 1'b0) begin n_fail++; $display("FAIL reset_change_valid: got %b want 0", change_valid); end
    n_checks++; if (change_amount !== 8'd0) begin n_fail++; $display("FAIL reset_change_amount: got %0d want 0", change_amount); end
    n_checks++; if (disp_status !== 4'b0) begin n_fail++; $display("FAIL reset_disp_after: got %b want 0000", disp_status); end
  endtask

  task automatic test_bounce();
    for (int k = 0; k < 4; k++) begin
      sw[1] = 1'b1; step(2); sw[1] = 1'b0; step(2);
    end
    step(8);
    do_frame();
    n_checks++; if (disp_status !== 4'b0) begin n_fail++; $display("FAIL bounce_rejected: got %b want 0000", disp_status); end
    sw[1] = 1'b1; step(10); sw[1] = 1'b0; step(2);
    m_sel = 1; m_active = 1;
    n_checks++; if (disp_status !== 4'b0) begin n_fail++; $display("FAIL bounce_before_frame: got %b want 0000", disp_status); end
    do_frame();
    n_checks++; if (disp_status !== 4'b0010) begin n_fail++; $display("FAIL bounce_after_frame: got %b want 0010", disp_status); end
    n_checks++; if (disp_log.size() !== 0) begin n_fail++; $display("FAIL bounce_no_dispense: got %0d want 0", disp_log.size()); end
    step(10);
  endtask

  task automatic test_purchase();
    int b0;
    do_cancel();
    n_checks++; if (chg_log.size() == 0 || chg_log[chg_log.size()-1] !== 8'd0) begin n_fail++; $display("FAIL purchase_clear_change: got size %0d want last 0", chg_log.size()); end
    do_press(2);
    do_coin();
    n_checks++; if (credit !== 8'd25) begin n_fail++; $display("FAIL purchase_coin1: got %0d want 25", credit); end
    b0 = busy_cycles;
    coin = 1'b1; step(3); coin = 1'b0; step(3);
    exp_disp.push_back(4'b0100); m_active = 0;
    n_checks++; if (credit !== 8'd0) begin n_fail++; $display("FAIL purchase_coin2_credit: got %0d want 0", credit); end
    n_checks++; if (disp_log.size() !== 1 || disp_log[0] !== 4'b0100) begin n_fail++; $display("FAIL purchase_dispense: got size %0d want one 0100", disp_log.size()); end
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL purchase_busy: got %b want 1", busy); end
    coin = 1'b1; step(3); coin = 1'b0; step(3);
    m_credit = 25;
    n_checks++; if (credit !== 8'd25) begin n_fail++; $display("FAIL purchase_coin3_credit: got %0d want 25", credit); end
    step(10);
    n_checks++; if (busy_cycles - b0 !== DSP) begin n_fail++; $display("FAIL purchase_busy_len: got %0d want %0d", busy_cycles - b0, DSP); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL purchase_idle: got %b want 0", busy); end
    do_frame();
    n_checks++; if (disp_status !== 4'b0) begin n_fail++; $display("FAIL purchase_frame: got %b want 0000", disp_status); end
  endtask

  task automatic test_simultaneous();
    do_cancel();
    n_checks++; if (chg_log[chg_log.size()-1] !== 8'd25) begin n_fail++; $display("FAIL simul_clear_change: got %0d want 25", chg_log[chg_log.size()-1]); end
    sw = 4'b1001; step(12); sw = 4'b0000; step(12);
    m_sel = 0; m_active = 1;
    do_frame();
    n_checks++; if (disp_status !== 4'b0001) begin n_fail++; $display("FAIL simul_sel: got %b want 0001", disp_status); end
    for (int k = 0; k < 3; k++) do_coin();
    n_checks++; if (credit !== 8'd75) begin n_fail++; $display("FAIL simul_credit: got %0d want 75", credit); end
    do_cancel();
    n_checks++; if (chg_log[chg_log.size()-1] !== 8'd75) begin n_fail++; $display("FAIL simul_change: got %0d want 75", chg_log[chg_log.size()-1]); end
    n_checks++; if (credit !== 8'd0) begin n_fail++; $display("FAIL simul_credit_clear: got %0d want 0", credit); end
    do_frame();
    n_checks++; if (disp_status !== 4'b0) begin n_fail++; $display("FAIL simul_frame: got %b want 0000", disp_status); end
  endtask

  task automatic test_saturation();
    for (int k = 1; k <= 11; k++) begin
      do_coin();
      n_checks++; if (credit !== 8'(m_credit)) begin n_fail++; $display("FAIL sat_coin%0d: got %0d want %0d", k, credit, m_credit); end
    end
    n_checks++; if (credit !== 8'd255) begin n_fail++; $display("FAIL sat_final: got %0d want 255", credit); end
    do_cancel();
    n_checks++; if (chg_log[chg_log.size()-1] !== 8'd255) begin n_fail++; $display("FAIL sat_change: got %0d want 255", chg_log[chg_log.size()-1]); end
  endtask

  task automatic test_dispense_guard();
    int nd, nc, b0;
    do_press(0);
    for (int k = 0; k < 3; k++) do_coin();
    nd = disp_log.size(); nc = chg_log.size(); b0 = busy_cycles;
    sw[1] = 1'b1; coin = 1'b1;
    step(2); cancel = 1'b1;
    step(1); coin = 1'b0;
    step(2); coin = 1'b1;
    step(3); coin = 1'b0; cancel = 1'b0;
    step(4); sw[1] = 1'b0;
    step(20);
    exp_disp.push_back(4'b0001); m_active = 0; m_credit = 25;
    n_checks++; if (disp_log.size() !== nd + 1 || disp_log[disp_log.size()-1] !== 4'b0001) begin n_fail++; $display("FAIL guard_dispense: got size %0d want %0d", disp_log.size(), nd + 1); end
    n_checks++; if (chg_log.size() !== nc) begin n_fail++; $display("FAIL guard_cancel_ignored: got %0d want %0d", chg_log.size(), nc); end
    n_checks++; if (credit !== 8'd25) begin n_fail++; $display("FAIL guard_coin_credit: got %0d want 25", credit); end
    n_checks++; if (busy_cycles - b0 !== DSP) begin n_fail++; $display("FAIL guard_busy_len: got %0d want %0d", busy_cycles - b0, DSP); end
    do_frame();
    n_checks++; if (disp_status !== 4'b0) begin n_fail++; $display("FAIL guard_select_ignored: got %b want 0000", disp_status); end
  endtask

  task automatic test_reset_mid_dispense();
    int nd;
    do_cancel();
    do_press(1);
    for (int k = 0; k < 5; k++) do_coin();
    do_frame();
    n_checks++; if (disp_status !== 4'b0010) begin n_fail++; $display("FAIL rst_pre_frame: got %b want 0010", disp_status); end
    coin = 1'b1; step(3); coin = 1'b0; step(2); coin = 1'b1; step(4);
    n_checks++; if (busy !== 1'b1 || credit !== 8'd25) begin n_fail++; $display("FAIL rst_pre_state: got busy %b credit %0d want 1 25", busy, credit); end
    exp_disp.push_back(4'b0010);
    nd = disp_log.size();
    #2 rst_n = 1'b0;
    #1;
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %b want 0", busy); end
    n_checks++; if (credit !== 8'd0) begin n_fail++; $display("FAIL rst_credit: got %0d want 0", credit); end
    n_checks++; if (disp_status !== 4'b0) begin n_fail++; $display("FAIL rst_disp_status: got %b want 0000", disp_status); end
    n_checks++; if (change_amount !== 8'd0 || change_valid !== 1'b0 || dispense !== 4'b0) begin n_fail++; $display("FAIL rst_pulses: got %0d %b %b want 0 0 0000", change_amount, change_valid, dispense); end
    coin = 1'b0;
    step(2); rst_n = 1'b1;
    m_credit = 0; m_active = 0;
    step(20);
    n_checks++; if (disp_log.size() !== nd) begin n_fail++; $display("FAIL rst_no_pulse: got %0d want %0d", disp_log.size(), nd); end
    n_checks++; if (busy !== 1'b0 || credit !== 8'd0) begin n_fail++; $display("FAIL rst_after: got busy %b credit %0d want 0 0", busy, credit); end
    do_frame();
    n_checks++; if (disp_status !== 4'b0) begin n_fail++; $display("FAIL rst_frame: got %b want 0000", disp_status); end
  endtask

  task automatic test_random();
    int a;
    for (int it = 0; it < 40; it++) begin
      a = $urandom_range(0, 4);
      case (a)
        0, 1: do_coin();
        2: do_press($urandom_range(0, 3));
        3: do_cancel();
        default: begin
          do_frame();
          n_checks++; if (disp_status !== m_disp()) begin n_fail++; $display("FAIL rand_disp it%0d: got %b want %b", it, disp_status, m_disp()); end
        end
      endcase
      n_checks++; if (credit !== 8'(m_credit)) begin n_fail++; $display("FAIL rand_credit it%0d: got %0d want %0d", it, credit, m_credit); end
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rand_busy it%0d: got %b want 0", it, busy); end
      n_checks++; if (disp_log.size() !== exp_disp.size()) begin n_fail++; $display("FAIL rand_disp_count it%0d: got %0d want %0d", it, disp_log.size(), exp_disp.size()); end
      n_checks++; if (chg_log.size() !== exp_chg.size()) begin n_fail++; $display("FAIL rand_chg_count it%0d: got %0d want %0d", it, chg_log.size(), exp_chg.size()); end
    end
    for (int i = 0; i < exp_disp.size() && i < disp_log.size(); i++) begin
      n_checks++; if (disp_log[i] !== exp_disp[i]) begin n_fail++; $display("FAIL log_dispense[%0d]: got %b want %b", i, disp_log[i], exp_disp[i]); end
    end
    for (int i = 0; i < exp_chg.size() && i < chg_log.size(); i++) begin
      n_checks++; if (chg_log[i] !== 8'(exp_chg[i])) begin n_fail++; $display("FAIL log_change[%0d]: got %0d want %0d", i, chg_log[i], exp_chg[i]); end
    end
  endtask

  initial begin
    test_reset();
    test_bounce();
    test_purchase();
    test_simultaneous();
    test_saturation();
    test_dispense_guard();
    test_reset_mid_dispense();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation time limit reached, got no completion want completion");
    $fatal(1, "watchdog");
  end

endmodule
